// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Tracks the destination registers of instructions that have left decode and
// are still in flight (stages 1..DEPTH, stage DEPTH being write-back). For
// each source operand of the instruction in decode it either picks the
// youngest in-flight producer to forward from, or requests a stall when that
// producer's result is not yet available (e.g. a load one stage behind).
//
// Parameters
//   AW          register address width
//   DEPTH       in-flight stages after issue (2..7); stage DEPTH is write-back
//   ALU_READY   first stage at which a non-load result can be forwarded
//   LOAD_READY  first stage at which a load result can be forwarded
//   FLUSH_DEPTH number of youngest stages killed by a flush (0..DEPTH-1)
//   SW          width of the forward selects
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   issue_valid                     decode holds an instruction
//   issue_rs, issue_rt              source register addresses
//   issue_rs_used, issue_rt_used    source is actually read
//   issue_wr_en, issue_wr_addr      destination write enable / address
//   issue_is_load                   result comes from data memory
//   flush                           taken branch/jump kill request
//   stall                           decode must hold (combinational)
//   issue_fire                      instruction leaves decode this cycle
//   fwd_sel_a, fwd_sel_b            0 = register file, k = stage k result
//   wb_valid, wb_addr               write-back stage contents
//   stall_count                     saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int unsigned AW          = 5,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned ALU_READY   = 1,
    parameter int unsigned LOAD_READY  = 2,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned SW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic          issue_rs_used,
    input  logic          issue_rt_used,
    input  logic          issue_wr_en,
    input  logic [AW-1:0] issue_wr_addr,
    input  logic          issue_is_load,
    input  logic          flush,
    output logic          stall,
    output logic          issue_fire,
    output logic [SW-1:0] fwd_sel_a,
    output logic [SW-1:0] fwd_sel_b,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [15:0]   stall_count
);

    // Per-stage entry; index 1 is the youngest (just issued).
    logic [DEPTH:1]         stg_valid;
    logic [DEPTH:1]         stg_load;
    logic [DEPTH:1][AW-1:0] stg_addr;

    typedef struct packed {
        logic          stall;
        logic [SW-1:0] sel;
    } lookup_t;

    lookup_t look_a;
    lookup_t look_b;

    // Youngest-match search for one source operand. Scanning upward from
    // stage 1 and latching only the first hit gives youngest-wins priority.
    // A hit that is not yet ready produces a stall and a zero select.
    function automatic lookup_t lookup(
        input logic [AW-1:0]         src,
        input logic                  used,
        input logic [DEPTH:1]        v,
        input logic [DEPTH:1]        ld,
        input logic [DEPTH:1][AW-1:0] a
    );
        lookup_t     res;
        logic        found;
        int unsigned need;
        res   = '0;
        found = 1'b0;
        if (used && (src != '0)) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found && v[k] && (a[k] == src)) begin
                    found = 1'b1;
                    need  = ld[k] ? LOAD_READY : ALU_READY;
                    if (k >= need) begin
                        res.sel = SW'(k);
                    end else begin
                        res.stall = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        look_a = lookup(issue_rs, issue_rs_used, stg_valid, stg_load, stg_addr);
        look_b = lookup(issue_rt, issue_rt_used, stg_valid, stg_load, stg_addr);
    end

    // Stage registers are already clear while rst_n is low; the explicit
    // rst_n gating keeps the handshake outputs quiet regardless of inputs.
    always_comb begin
        stall      = rst_n & issue_valid & (look_a.stall | look_b.stall);
        issue_fire = rst_n & issue_valid & ~stall & ~flush;
        fwd_sel_a  = rst_n ? look_a.sel : '0;
        fwd_sel_b  = rst_n ? look_b.sel : '0;
    end

    assign wb_valid = stg_valid[DEPTH];
    assign wb_addr  = stg_addr[DEPTH];

    // Writes to r0 never enter as valid entries, so r0 can never match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid   <= '0;
            stg_load    <= '0;
            stg_addr    <= '0;
            stall_count <= '0;
        end else begin
            stg_valid[1] <= issue_fire & issue_wr_en & (issue_wr_addr != '0);
            stg_addr[1]  <= issue_wr_addr;
            stg_load[1]  <= issue_is_load;
            // On flush the youngest FLUSH_DEPTH entries are invalidated as
            // they shift, so stage FLUSH_DEPTH+1 receives a bubble.
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                stg_valid[k] <= stg_valid[k-1] & ~(flush && ((k - 1) <= FLUSH_DEPTH));
                stg_addr[k]  <= stg_addr[k-1];
                stg_load[k]  <= stg_load[k-1];
            end
            if (issue_valid && stall && !flush && (stall_count != '1)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- AW, 5, register address width.
- DEPTH, 3, in-flight stages after issue; stage DEPTH is write-back; legal 2..7.
- ALU_READY, 1, first stage at which a non-load result is forwardable.
- LOAD_READY, 2, first stage at which a load result is forwardable; 1<=ALU_READY<=LOAD_READY<=DEPTH.
- FLUSH_DEPTH, 1, number of youngest stages killed by flush; legal 0..DEPTH-1.
- SW, clog2(DEPTH+1), width of the forward selects.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- issue_valid, in, 1, decode holds an instruction.
- issue_rs / issue_rt, in, AW, source register addresses.
- issue_rs_used / issue_rt_used, in, 1, source actually read.
- issue_wr_en, in, 1, instruction writes a register.
- issue_wr_addr, in, AW, destination register.
- issue_is_load, in, 1, result comes from data memory.
- flush, in, 1, taken branch/jump kill request.
- stall, out, 1, decode must hold (combinational).
- issue_fire, out, 1, equals issue_valid & ~stall & ~flush.
- fwd_sel_a / fwd_sel_b, out, SW, 0 = register file, k = result of stage k.
- wb_valid, out, 1, stage DEPTH holds a valid write.
- wb_addr, out, AW, stage DEPTH destination.
- stall_count, out, 16, saturating stall-cycle counter.

Function
REQ-003 The block SHALL hold per stage k (1..DEPTH) a register {valid, addr, is_load}.
REQ-004 Each cycle, stage k SHALL load stage k-1 for k>=2; stage 1 SHALL load {issue_fire & issue_wr_en & (issue_wr_addr!=0), issue_wr_addr, issue_is_load}.
REQ-005 A stalled or flushed cycle SHALL insert an invalid entry (bubble) at stage 1 while older stages still advance.
REQ-006 When flush=1, entries in stages 1..FLUSH_DEPTH SHALL be invalidated instead of advancing, i.e. stage FLUSH_DEPTH+1 receives invalid; with FLUSH_DEPTH=0, flush only blocks issue.
REQ-007 For each used source r!=0, the block SHALL find the smallest k with valid[k] & addr[k]==r (youngest match wins).
REQ-008 If a match exists and k >= (is_load[k] ? LOAD_READY : ALU_READY), fwd_sel SHALL be k; if it exists but is not ready, stall SHALL be 1.
REQ-009 If no match exists, or r==0, or the source is unused, fwd_sel SHALL be 0 and that source SHALL not stall.
REQ-010 stall SHALL be the OR of both sources' not-ready conditions, gated by issue_valid; fwd_sel is meaningful only when stall=0.
REQ-011 A match at stage DEPTH SHALL select DEPTH (forward beats same-cycle register-file write).
REQ-012 wb_valid and wb_addr SHALL be driven directly from stage DEPTH registers.
REQ-013 stall_count SHALL increment when issue_valid & stall & ~flush, and SHALL saturate at 16'hFFFF.
REQ-014 When flush and stall are both 1, flush SHALL take precedence: issue_fire=0 and no count.
REQ-015 All outputs except the stage registers and stall_count SHALL be combinational; issue-to-forward latency SHALL be 1 cycle for an ALU result when ALU_READY=1.

Reset
REQ-016 When rst_n=0, the block SHALL immediately clear all stage valid bits, addr, is_load and stall_count to 0.
REQ-017 During reset, stall, issue_fire, wb_valid and fwd_sel_a/b SHALL be 0, and wb_addr SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight entries; the first cycle after deassertion SHALL see an empty scoreboard.

Verification (defaults DEPTH=3, ALU_READY=1, LOAD_READY=2, FLUSH_DEPTH=1)
REQ-019 Reset: assert rst_n=0 with entries in flight -> wb_valid=0, stall=0, stall_count=0 immediately.
REQ-020 ALU back-to-back: issue add wr r3, then next cycle rs=3 -> stall=0, fwd_sel_a=1; two cycles later wb_valid=1, wb_addr=3.
REQ-021 Load-use: issue lw wr r4, then rs=4 held valid -> stall=1 for one cycle, then fwd_sel_a=2, stall_count=1.
REQ-022 r0 and youngest match: write r0 then read r0 -> fwd_sel=0, no stall; then write r5 twice in a row and read r5 -> fwd_sel=1.
REQ-023 Flush: issue lw wr r6, next cycle flush=1 with issue_valid=1 -> issue_fire=0, r6 entry killed; following read of r6 -> fwd_sel=0, stall=0, stall_count unchanged.
REQ-024 Saturation: hold a permanent load-use stall for 70000 cycles (forced entry) -> stall_count=16'hFFFF and no wrap.
